// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 round-key expansion controller with registered round-key read port
// Optional KEY_ZEROIZE_EN adds key_clr (synchronous zeroize of all key material).
module keyexpansion (
    input  logic [127:0] key,
    input  logic [3:0]   key_num,
    output logic [127:0] next_key
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

    assign w0 = key[127:96];
    assign w1 = key[95:64];
    assign w2 = key[63:32];
    assign w3 = key[31:0];
    assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon(key_num), 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};
endmodule

module key_schedule_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
`ifdef KEY_ZEROIZE_EN
    input  logic         key_clr,
`endif
    input  logic [3:0]   rk_idx,
    output logic         busy,
    output logic         key_ready,
    output logic [127:0] rk_out
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic [127:0] rk_mem [0:ROUNDS];
    logic [127:0] cur_key, nxt_key, rd_data;
    logic         clr, last, load_acc;

`ifdef KEY_ZEROIZE_EN
    assign clr = key_clr;
`else
    assign clr = 1'b0;
`endif

    assign last     = (cnt == LAST);
    assign load_acc = key_load && (state != EXPAND) && !clr;

    keyexpansion u_kexp (
        .key      (cur_key),
        .key_num  (cnt),
        .next_key (nxt_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        key_ready = 1'b0;
        case (state)
            IDLE:    if (key_load) state_nxt = EXPAND;
            EXPAND: begin
                busy = 1'b1;
                if (last) state_nxt = READY;
            end
            READY: begin
                key_ready = 1'b1;
                if (key_load) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // Index-compare muxes keep the 4-bit indices legal for any ROUNDS
    always_comb begin
        cur_key = '0;
        rd_data = '0;
        for (int i = 0; i <= ROUNDS; i++) begin
            if (cnt == 4'(i))    cur_key = rk_mem[i];
            if (rk_idx == 4'(i)) rd_data = rk_mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rk_out <= '0;
            for (int i = 0; i <= ROUNDS; i++) rk_mem[i] <= '0;
        end else if (clr) begin
            cnt    <= '0;
            rk_out <= '0;
            for (int i = 0; i <= ROUNDS; i++) rk_mem[i] <= '0;
        end else begin
            rk_out <= rd_data;
            if (load_acc) begin
                rk_mem[0] <= key_in;
                cnt       <= '0;
            end else if (state == EXPAND) begin
                for (int i = 1; i <= ROUNDS; i++) begin
                    if (cnt == 4'(i - 1)) rk_mem[i] <= nxt_key;
                end
                if (!last) cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl (ROUNDS=10 and ROUNDS=1 instances)
module tb_key_schedule_ctrl;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load, key_load1;
    logic [3:0]   rk_idx, rk_idx1;
    logic         busy, key_ready, busy1, key_ready1;
    logic [127:0] rk_out, rk_out1;
`ifdef KEY_ZEROIZE_EN
    logic         key_clr, key_clr1;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl [5];

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk [0:10];

    always #5 clk = ~clk;

    key_schedule_ctrl #(.ROUNDS(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
`ifdef KEY_ZEROIZE_EN
        .key_clr(key_clr),
`endif
        .rk_idx(rk_idx), .busy(busy), .key_ready(key_ready), .rk_out(rk_out)
    );

    key_schedule_ctrl #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load1),
`ifdef KEY_ZEROIZE_EN
        .key_clr(key_clr1),
`endif
        .rk_idx(rk_idx1), .busy(busy1), .key_ready(key_ready1), .rk_out(rk_out1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables of generator 3, then the bitwise affine map
    task automatic build_sbox();
        logic [7:0] ex [256];
        logic [7:0] lg [256];
        logic [7:0] p, inv, s, c;
        c = 8'h63;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = p;
            lg[p] = i[7:0];
            p = p ^ xt(p);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
            sbox_tab[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]] ^ rc, sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Returns the edge (load edge = 1) on which key_ready rose; 40 means it never did
    task automatic load_and_wait(input logic [127:0] k, input int reload_at, output int edges);
        int n;
        bit busy_ok;
        @(negedge clk);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!key_ready && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (n == reload_at - 1) begin
                key_in   = ~k;
                key_load = 1'b1;
            end else begin
                key_load = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        key_load = 1'b0;
        key_in   = k;
        edges = n;
        check("busy_during_expand", 128'(busy_ok), 128'd1);
        check("busy_after_ready", 128'(busy), 128'd0);
    endtask

    task automatic read_idx(input logic [3:0] idx, output logic [127:0] data);
        @(negedge clk);
        rk_idx = idx;
        @(negedge clk);
        data = rk_out;
    endtask

    initial begin
        int edges, reload_at;
        logic [127:0] d, k, e;
        logic [3:0] idx;

        tbl[0] = '{4'd1,  RK1};
        tbl[1] = '{4'd10, RK10};
        tbl[2] = '{4'd0,  KEY};
        tbl[3] = '{4'd11, 128'h0};
        tbl[4] = '{4'd15, 128'h0};
        build_sbox();

        rst_n = 1'b0; key_in = '0; key_load = 1'b0; key_load1 = 1'b0; rk_idx = '0; rk_idx1 = '0;
`ifdef KEY_ZEROIZE_EN
        key_clr = 1'b0; key_clr1 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_key_ready", 128'(key_ready), 128'd0);
        check("reset_rk_out", rk_out, 128'h0);
        rst_n = 1'b1;

        load_and_wait(KEY, 0, edges);
        check("latency_r10", 128'(edges), 128'd11);
        for (int i = 0; i < 5; i++) begin
            read_idx(tbl[i].idx, d);
            check($sformatf("table_idx%0d", tbl[i].idx), d, tbl[i].exp);
        end

        load_and_wait(KEY, 5, edges);
        check("latency_ignored_reload", 128'(edges), 128'd11);
        read_idx(4'd1, d);
        check("reload_ignored_rk1", d, RK1);
        read_idx(4'd10, d);
        check("reload_ignored_rk10", d, RK10);

        @(negedge clk);
        key_in = KEY; key_load = 1'b1; rk_idx = 4'd0;
        @(negedge clk);
        key_load = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_rk_out", rk_out, KEY);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 128'(busy), 128'd0);
        check("async_reset_key_ready", 128'(key_ready), 128'd0);
        check("async_reset_rk_out", rk_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        read_idx(4'd1, d);
        check("post_reset_rk1", d, 128'h0);
        read_idx(4'd0, d);
        check("post_reset_rk0", d, 128'h0);

        @(negedge clk);
        key_in = KEY; key_load1 = 1'b1;
        @(negedge clk);
        key_load1 = 1'b0;
        edges = 1;
        while (!key_ready1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("latency_r1", 128'(edges), 128'd2);
        rk_idx1 = 4'd1;
        @(negedge clk);
        check("r1_rk1", rk_out1, RK1);
        rk_idx1 = 4'd2;
        @(negedge clk);
        check("r1_rk2_out_of_range", rk_out1, 128'h0);

        for (int it = 0; it < 8; it++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            reload_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 10)) : 0;
            load_and_wait(k, reload_at, edges);
            check($sformatf("rand%0d_latency", it), 128'(edges), 128'd11);
            model_expand(k);
            for (int j = 0; j < 4; j++) begin
                idx = 4'($urandom_range(0, 15));
                e = (idx <= 4'd10) ? exp_rk[idx] : 128'h0;
                read_idx(idx, d);
                check($sformatf("rand%0d_idx%0d", it, idx), d, e);
            end
        end

`ifdef KEY_ZEROIZE_EN
        @(negedge clk);
        rk_idx = 4'd0;
        key_clr = 1'b1; key_load = 1'b1; key_in = KEY;
        @(negedge clk);
        key_clr = 1'b0; key_load = 1'b0;
        check("zeroize_key_ready", 128'(key_ready), 128'd0);
        check("zeroize_busy", 128'(busy), 128'd0);
        check("zeroize_rk_out", rk_out, 128'h0);
        for (int i = 0; i <= 10; i++) begin
            read_idx(4'(i), d);
            check($sformatf("zeroize_idx%0d", i), d, 128'h0);
        end
        load_and_wait(KEY, 0, edges);
        check("post_zeroize_latency", 128'(edges), 128'd11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
